// File: rtl/uart_wb_pkg.sv
// Shared constants and FSM state type for the UART Wishbone poller.
package uart_wb_pkg;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;

    localparam int STAT_RX_READY = 0;
    localparam int STAT_TX_IDLE  = 5;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        DECIDE,
        RX_RD,
        TX_WR,
        TX_GAP
    } state_e;

endpackage

// File: rtl/uart_wb_poller_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on data_o
// whenever empty_o is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_wb_poller.sv
// Wishbone initiator that polls a UART controller's status register, drains
// received bytes into an RX FIFO and feeds TX FIFO bytes to its data register.
module uart_wb_poller
    import uart_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_we_o,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  logic [7:0]              tx_data_i,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output logic [7:0]              rx_data_o,
    output logic                    err_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADR_DATA   = ADDR_WIDTH'(BASE_ADDR + 32'(REG_DATA));
    localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = ADDR_WIDTH'(BASE_ADDR + 32'(REG_STATUS));
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [7:0]              status_q, status_d;
    logic [7:0]              tmo_q, tmo_d;
    logic                    gap_q, gap_d;
    logic                    err_q, err_d;

    logic                    ack_ok, timeout;
    logic                    rx_push, tx_pop;
    logic                    rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]              tx_head;
    logic                    unused_dat_hi;

    assign unused_dat_hi = ^wb_dat_i;

    // An ack only counts while our own access is outstanding.
    assign ack_ok  = cyc_q & wb_ack_i;
    assign timeout = cyc_q & ~wb_ack_i & (tmo_q == TMO_LAST);

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign err_o      = err_q;
    assign tx_ready_o = ~tx_full;
    assign rx_valid_o = ~rx_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            status_q <= '0;
            tmo_q    <= '0;
            gap_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = POLL;
            POLL: begin
                if (timeout)     state_d = IDLE;
                else if (ack_ok) state_d = DECIDE;
            end
            DECIDE: begin
                if (status_q[STAT_RX_READY] && !rx_full)     state_d = RX_RD;
                else if (status_q[STAT_TX_IDLE] && !tx_empty) state_d = TX_WR;
                else                                          state_d = IDLE;
            end
            RX_RD: begin
                if (timeout || ack_ok) state_d = IDLE;
            end
            TX_WR: begin
                if (timeout)     state_d = IDLE;
                else if (ack_ok) state_d = TX_GAP;
            end
            TX_GAP: begin
                if (gap_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        status_d = status_q;
        tmo_d    = cyc_q ? tmo_q + 8'd1 : 8'd0;
        gap_d    = 1'b0;
        err_d    = err_q | timeout;
        rx_push  = 1'b0;
        tx_pop   = 1'b0;

        case (state_q)
            POLL: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = ADR_STATUS;
                    dat_d = '0;
                    sel_d = SEL_W'(1);
                end
                if (ack_ok) status_d = wb_dat_i[7:0];
            end
            RX_RD: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = ADR_DATA;
                    dat_d = '0;
                    sel_d = SEL_W'(1);
                end
                rx_push = ack_ok;
            end
            TX_WR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = ADR_DATA;
                    dat_d = {{(DATA_WIDTH-8){1'b0}}, tx_head};
                    sel_d = SEL_W'(1);
                end
                tx_pop = ack_ok;
            end
            TX_GAP:  gap_d = ~gap_q;
            default: ;
        endcase

        // Completion or abort: release the bus for at least one idle cycle.
        if (ack_ok || timeout) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .data_i  (wb_dat_i[7:0]),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

endmodule

// File: tb/tb_uart_wb_poller.sv
// Directed bench for uart_wb_poller: a small UART-controller slave model,
// a bus monitor, a vector table and hand-written multi-cycle sequences.
module tb_uart_wb_poller;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        tx_valid_i, tx_ready_o;
    logic [7:0]  tx_data_i;
    logic        rx_valid_o, rx_ready_i;
    logic [7:0]  rx_data_o;
    logic        err_o;

    always #5 clk = ~clk;

    uart_wb_poller dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_i  (tx_data_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_o  (rx_data_o),
        .err_o      (err_o)
    );

    // Slave model: registered ack one cycle after stb, like the UART controller.
    logic       s_rx_rdy, s_tx_idle, s_rx_sticky, s_ack_en;
    logic [7:0] s_rx_byte;

    always @(posedge clk) begin
        if (rst_i) begin
            wb_ack_i <= 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && s_ack_en) begin
            wb_ack_i <= 1'b1;
            if (wb_adr_o == BASE + 32'h4) begin
                wb_dat_i <= {24'h0, 2'b00, s_tx_idle, 4'b0000, s_rx_rdy};
            end else if (!wb_we_o) begin
                wb_dat_i <= {24'h0, s_rx_byte};
                if (s_rx_sticky) s_rx_byte = s_rx_byte + 8'd1;
                else             s_rx_rdy = 1'b0;
            end else begin
                wb_dat_i <= 32'h0;
            end
        end else begin
            wb_ack_i <= 1'b0;
        end
    end

    // Bus monitor, sampled on the falling edge.
    int         cyc_n = 0;
    int         n_poll, n_rd, n_wr, n_bad, first_we;
    int         stb_run, last_run, last_rise, prev_rise, wr_ack_cyc, rise_after_wr;
    logic [7:0] last_wr;
    logic       stb_prev = 1'b0, ack_prev = 1'b0;
    logic [31:0] adr_prev, dat_prev;
    logic       we_prev;

    task automatic clear_mon();
        n_poll = 0; n_rd = 0; n_wr = 0; n_bad = 0; first_we = -1;
        stb_run = 0; last_run = 0; last_rise = 0; prev_rise = 0;
        wr_ack_cyc = 0; rise_after_wr = 0; last_wr = 8'h00;
    endtask

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (wb_stb_o) begin
            stb_run = stb_run + 1;
        end else if (stb_run > 0) begin
            last_run = stb_run;
            stb_run  = 0;
        end
        if (wb_stb_o && !stb_prev) begin
            prev_rise = last_rise;
            last_rise = cyc_n;
            if (wr_ack_cyc > 0 && rise_after_wr == 0) rise_after_wr = cyc_n;
        end
        if (wb_stb_o && stb_prev && !ack_prev &&
            (wb_adr_o != adr_prev || wb_we_o != we_prev || wb_dat_o != dat_prev))
            n_bad = n_bad + 1;
        if (wb_cyc_o != wb_stb_o) n_bad = n_bad + 1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            if (wb_sel_o != 4'b0001) n_bad = n_bad + 1;
            if (wb_adr_o == BASE + 32'h4) begin
                n_poll = n_poll + 1;
                if (wb_we_o) n_bad = n_bad + 1;
            end else if (wb_adr_o == BASE) begin
                if (first_we < 0) first_we = int'(wb_we_o);
                if (wb_we_o) begin
                    n_wr       = n_wr + 1;
                    last_wr    = wb_dat_o[7:0];
                    wr_ack_cyc = cyc_n;
                    if (wb_dat_o[31:8] != 24'h0) n_bad = n_bad + 1;
                end else begin
                    n_rd = n_rd + 1;
                end
            end else begin
                n_bad = n_bad + 1;
            end
        end
        stb_prev = wb_stb_o;
        ack_prev = wb_ack_i;
        adr_prev = wb_adr_o;
        dat_prev = wb_dat_o;
        we_prev  = wb_we_o;
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        clear_mon();
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        tx_valid_i = 1'b1;
        tx_data_i  = b;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
    endtask

    typedef struct {
        logic       rx_rdy;
        logic       tx_idle;
        logic [7:0] rx_byte;
        logic       push;
        logic [7:0] tx_byte;
        int         exp_rd;
        int         exp_wr;
        logic       exp_rxv;
        logic [7:0] exp_rx;
        logic [7:0] exp_wr_dat;
        int         exp_first_we;
    } vec_t;

    vec_t vt [6];

    initial begin
        rst_i = 1'b1; tx_valid_i = 1'b0; tx_data_i = 8'h00; rx_ready_i = 1'b0;
        s_rx_rdy = 1'b0; s_tx_idle = 1'b0; s_rx_sticky = 1'b0; s_ack_en = 1'b1;
        s_rx_byte = 8'h00;
        clear_mon();

        vt[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00, -1};
        vt[1] = '{1'b1, 1'b0, 8'h41, 1'b0, 8'h00, 1, 0, 1'b1, 8'h41, 8'h00,  0};
        vt[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h55, 0, 1, 1'b0, 8'h00, 8'h55,  1};
        vt[3] = '{1'b1, 1'b1, 8'h7A, 1'b1, 8'h5A, 1, 1, 1'b1, 8'h7A, 8'h5A,  0};
        vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 0, 0, 1'b0, 8'h00, 8'h00, -1};
        vt[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00, -1};

        // Reset state, sampled while reset is held.
        repeat (3) @(negedge clk);
        check("rst_cyc", int'(wb_cyc_o), 0);
        check("rst_stb", int'(wb_stb_o), 0);
        check("rst_we", int'(wb_we_o), 0);
        check("rst_adr", int'(wb_adr_o), 0);
        check("rst_dat", int'(wb_dat_o), 0);
        check("rst_sel", int'(wb_sel_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_rxv", int'(rx_valid_o), 0);
        check("rst_txrdy", int'(tx_ready_o), 1);

        // First poll: stb one cycle after entering POLL, held for two cycles.
        rst_i = 1'b0;
        clear_mon();
        @(negedge clk); check("poll_stb_c1", int'(wb_stb_o), 0);
        @(negedge clk); check("poll_stb_c2", int'(wb_stb_o), 1);
        check("poll_adr", int'(wb_adr_o), int'(BASE + 32'h4));
        @(negedge clk); check("poll_stb_c3", int'(wb_stb_o), 1);
        @(negedge clk); check("poll_stb_c4", int'(wb_stb_o), 0);
        repeat (20) @(negedge clk);
        check("repoll_period", last_rise - prev_rise, 5);

        // Table-driven status/data scenarios.
        for (int i = 0; i < 6; i++) begin
            s_rx_rdy = vt[i].rx_rdy; s_tx_idle = vt[i].tx_idle;
            s_rx_byte = vt[i].rx_byte; s_rx_sticky = 1'b0; s_ack_en = 1'b1;
            do_reset();
            if (vt[i].push) push_tx(vt[i].tx_byte);
            repeat (40) @(negedge clk);
            $display("vector %0d: polls=%0d rd=%0d wr=%0d", i, n_poll, n_rd, n_wr);
            check($sformatf("v%0d_rd", i), n_rd, vt[i].exp_rd);
            check($sformatf("v%0d_wr", i), n_wr, vt[i].exp_wr);
            check($sformatf("v%0d_first_we", i), first_we, vt[i].exp_first_we);
            check($sformatf("v%0d_rxv", i), int'(rx_valid_o), int'(vt[i].exp_rxv));
            check($sformatf("v%0d_bus_rules", i), n_bad, 0);
            check($sformatf("v%0d_polling", i), int'(n_poll >= 3), 1);
            check($sformatf("v%0d_err", i), int'(err_o), 0);
            check($sformatf("v%0d_txrdy", i), int'(tx_ready_o), 1);
            if (vt[i].exp_wr > 0)
                check($sformatf("v%0d_wr_dat", i), int'(last_wr), int'(vt[i].exp_wr_dat));
            if (vt[i].exp_rxv) begin
                check($sformatf("v%0d_rx_data", i), int'(rx_data_o), int'(vt[i].exp_rx));
                pop_rx();
                check($sformatf("v%0d_rxv_after_pop", i), int'(rx_valid_o), 0);
            end
        end

        // Gap between a TX write ack and the next poll strobe.
        s_rx_rdy = 1'b0; s_tx_idle = 1'b1; s_rx_sticky = 1'b0; s_ack_en = 1'b1;
        do_reset();
        push_tx(8'h55);
        repeat (40) @(negedge clk);
        check("tx_gap_cycles", rise_after_wr - wr_ack_cyc, 5);
        check("tx_single_write", n_wr, 1);

        // RX FIFO fills; no data read while full, read resumes after one pop.
        s_rx_rdy = 1'b1; s_tx_idle = 1'b0; s_rx_sticky = 1'b1; s_rx_byte = 8'h10;
        do_reset();
        repeat (150) @(negedge clk);
        check("rxfull_reads", n_rd, 8);
        check("rxfull_head", int'(rx_data_o), 8'h10);
        repeat (40) @(negedge clk);
        check("rxfull_no_more_reads", n_rd, 8);
        pop_rx();
        repeat (20) @(negedge clk);
        check("rxfull_read_after_pop", n_rd, 9);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rxfull_order_%0d", k), int'(rx_data_o), 8'h11 + k);
            pop_rx();
        end

        // Slave never acks: abort after ACK_TIMEOUT strobe cycles, sticky err.
        s_rx_rdy = 1'b0; s_tx_idle = 1'b0; s_rx_sticky = 1'b0; s_ack_en = 1'b0;
        do_reset();
        repeat (300) @(negedge clk);
        check("tmo_stb_cycles", last_run, 255);
        check("tmo_err_set", int'(err_o), 1);
        check("tmo_no_acks", n_poll, 0);
        s_ack_en = 1'b1;
        repeat (30) @(negedge clk);
        check("tmo_polling_resumed", int'(n_poll > 0), 1);
        check("tmo_err_sticky", int'(err_o), 1);
        s_ack_en = 1'b0;
        repeat (5) @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_cyc", int'(wb_cyc_o), 0);
        check("midrst_adr", int'(wb_adr_o), 0);
        check("midrst_err", int'(err_o), 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
